// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multiplies and divides are computed at issue into pending registers and
// committed to HI/LO together after a fixed busy interval.
module mdu #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  operation,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        busy,
  output logic [31:0] data_read
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;

  localparam logic [2:0] OP_READ_HI  = 3'd0;
  localparam logic [2:0] OP_READ_LO  = 3'd1;
  localparam logic [2:0] OP_WRITE_HI = 3'd2;
  localparam logic [2:0] OP_WRITE_LO = 3'd3;
  localparam logic [2:0] OP_MUL_S    = 3'd4;
  localparam logic [2:0] OP_MUL_U    = 3'd5;
  localparam logic [2:0] OP_DIV_S    = 3'd6;
  localparam logic [2:0] OP_DIV_U    = 3'd7;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic                pend_we_q, pend_we_d;
  logic                busy_d;

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                div_signed;
  logic [DATA_W-1:0]   div_a, div_b, div_b_safe;
  logic [DATA_W-1:0]   q_mag, r_mag, q_res, r_res;

  // Issue-time arithmetic: signed divide via magnitudes so that the
  // most-negative / -1 case wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prod_s     = {{DATA_W{operand1[DATA_W-1]}}, operand1} *
                 {{DATA_W{operand2[DATA_W-1]}}, operand2};
    prod_u     = {{DATA_W{1'b0}}, operand1} * {{DATA_W{1'b0}}, operand2};
    div_signed = (operation == OP_DIV_S);
    div_a      = (div_signed && operand1[DATA_W-1]) ? -operand1 : operand1;
    div_b      = (div_signed && operand2[DATA_W-1]) ? -operand2 : operand2;
    div_b_safe = (div_b == '0) ? DATA_W'(1) : div_b;
    q_mag      = div_a / div_b_safe;
    r_mag      = div_a % div_b_safe;
    q_res      = (div_signed && (operand1[DATA_W-1] ^ operand2[DATA_W-1])) ? -q_mag : q_mag;
    r_res      = (div_signed && operand1[DATA_W-1]) ? -r_mag : r_mag;
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_WRITE_HI: hi_d = operand1;
            OP_WRITE_LO: lo_d = operand1;
            OP_MUL_S: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_we_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = BUSY;
            end
            OP_MUL_U: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_we_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = BUSY;
            end
            OP_DIV_S, OP_DIV_U: begin
              pend_hi_d = r_res;
              pend_lo_d = q_res;
              pend_we_d = (operand2 != '0);
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = BUSY;
            end
            OP_READ_HI, OP_READ_LO: ;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_we_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  // State and architectural registers; reset overrides any commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      busy      <= busy_d;
    end
  end

  // Zero-latency HI/LO read port.
  always_comb begin
    case (operation)
      OP_READ_HI: data_read = hi_q;
      OP_READ_LO: data_read = lo_q;
      default:    data_read = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops
// compared against an arithmetic model of HI/LO.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic [31:0] data_read;

  int tests  = 0;
  int failed = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand1(operand1), .operand2(operand2), .busy(busy), .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reads HI and LO through the combinational port and compares to the model.
  task automatic check_regs(input string tag);
    operation = 3'd0; #1;
    check({tag, "_hi"}, data_read, hi_m);
    operation = 3'd1; #1;
    check({tag, "_lo"}, data_read, lo_m);
    operation = 3'd0;
  endtask

  // Applies the architectural effect of one op to the model.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd2: hi_m = a;
      3'd3: lo_m = a;
      3'd4: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd5: begin p = {32'b0, a} * {32'b0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd6: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      3'd7: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      default: ;
    endcase
  endtask

  // Drives one start for a single cycle; returns at the following negedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operation = op; operand1 = a; operand2 = b;
    @(negedge clk);
    start = 1'b0; operation = 3'd0; operand1 = '0; operand2 = '0;
  endtask

  // Issues an op from IDLE, checks busy duration and final HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc, exp_cyc;
    exp_cyc = (op == 3'd4 || op == 3'd5) ? 5 : (op >= 3'd6) ? 10 : 0;
    issue(op, a, b);
    model_op(op, a, b);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check_regs(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operation = 3'd0; operand1 = '0; operand2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check_regs("reset");

    // Multiply examples
    run_op("mul_s", 3'd4, 32'hFFFFFFFE, 32'h00000003);
    check("mul_s_hi_const", hi_m, 32'hFFFFFFFF);
    run_op("mul_u", 3'd5, 32'hFFFFFFFE, 32'h00000003);
    check("mul_u_hi_const", hi_m, 32'h00000002);

    // Divide examples
    run_op("div_s", 3'd6, 32'hFFFFFFF9, 32'd2);
    check("div_s_lo_const", lo_m, 32'hFFFFFFFD);
    run_op("div_u", 3'd7, 32'd7, 32'd2);

    // Write/read and divide by zero
    issue(3'd2, 32'h12345678, 32'h0);
    operation = 3'd0; #1;
    check("write_hi_read", data_read, 32'h12345678);
    model_op(3'd2, 32'h12345678, 32'h0);
    run_op("div_zero", 3'd7, 32'd5, 32'd0);
    check("div_zero_hi_const", hi_m, 32'h12345678);

    // Overflow divide
    run_op("div_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);

    // Starts during busy are ignored; reads return old values
    run_op("clr_hi", 3'd2, 32'h0, 32'h0);
    run_op("clr_lo", 3'd3, 32'h0, 32'h0);
    issue(3'd4, 32'd3, 32'd4);
    check("ign_busy_set", 32'(busy), 32'd1);
    issue(3'd3, 32'h0000AAAA, 32'h0);
    check_regs("ign_read_in_busy");
    issue(3'd6, 32'd100, 32'd7);
    model_op(3'd4, 32'd3, 32'd4);
    repeat (10) @(negedge clk);
    check("ign_busy_done", 32'(busy), 32'd0);
    check("ign_lo_const", lo_m, 32'd12);
    check_regs("ign_final");

    // Reset in the middle of a divide
    issue(3'd7, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    check("rst_mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check_regs("rst_mid");
    repeat (12) @(negedge clk);
    check("rst_no_late_busy", 32'(busy), 32'd0);
    check_regs("rst_no_late");

    // Reset exactly on the commit edge
    issue(3'd5, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_regs("rst_commit_edge");
    // First cycle after reset accepts a start
    run_op("post_rst_write", 3'd3, 32'hCAFEF00D, 32'h0);

    // Read ops with start change nothing
    run_op("read_noop0", 3'd0, 32'hDEADBEEF, 32'h1);
    run_op("read_noop1", 3'd1, 32'hDEADBEEF, 32'h1);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(2, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      run_op("rand", op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
